// File: rtl/heap_sort_controller.sv
// heap_sort_controller
//   Sequencer sitting above the level-0 root record of a pipelined heapsort
//   array. After reset (or a finished batch) it holds the sorting nodes in
//   clear, then streams a batch into the heap root with replace-top
//   operations paced to the node step period. Finally it drains the heap by
//   replacing the root with all-ones sentinels and emits the batch in
//   ascending order.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_data/valid/last    input word stream; in_ready is the acceptance qualifier
//   out_data/valid/ready  sorted output stream
//   root_q                root record read data (1-cycle latency, address 0)
//   root_data/addr/wren   root record write port
//   initialize            level enable for all sorting nodes (0 = clear)
//   update_out            one-cycle pulse into the level-1 node update_in
//   address_updated_out   root index, always 0
//   sort_done             one-cycle pulse after the last output handshake
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | initialize low, node memories clearing for CLEAR_CYCLES
// S_LOAD  | accepting input words, one replace-top per ISSUE_GAP
// S_DRAIN | replacing root with sentinels, emitting popped words
module heap_sort_controller #(
  parameter int WIDTH        = 15,
  parameter int LEVELS       = 2,
  parameter int CLEAR_CYCLES = 8,
  parameter int ISSUE_GAP    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] in_data,
  input  logic           in_valid,
  input  logic           in_last,
  output logic           in_ready,
  output logic [WIDTH:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic [WIDTH:0] root_q,
  output logic [WIDTH:0] root_data,
  output logic           root_addr,
  output logic           root_wren,
  output logic           initialize,
  output logic           update_out,
  output logic           address_updated_out,
  output logic           sort_done
);

  localparam int CAPACITY = 2 ** (LEVELS + 1) - 1;
  localparam int CNT_W    = $clog2(CAPACITY + 1);
  localparam int CLR_W    = $clog2(CLEAR_CYCLES + 1);
  localparam int GAP_W    = $clog2(ISSUE_GAP + 1);

  localparam logic [CNT_W-1:0] CAP_C      = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CAP_M1     = CNT_W'(CAPACITY - 1);
  localparam logic [CLR_W-1:0] CLR_TC     = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [CLR_W-1:0] r_clr_cnt;
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0] r_n;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_keep;
  logic [WIDTH:0]   r_out_data;
  logic             r_out_valid;
  logic [WIDTH:0]   r_root_data;
  logic             r_root_wren;
  logic             r_update;
  logic             r_initialize;
  logic             r_sort_done;

  logic w_in_ready;
  logic w_accept;
  logic w_drain_issue;
  logic w_out_hs;

  assign w_in_ready    = (r_state == S_LOAD) && (r_gap_cnt == '0);
  assign w_accept      = w_in_ready && in_valid;
  assign w_out_hs      = r_out_valid && out_ready;
  // A drain op may only be launched once the previous word is gone (or
  // leaving this cycle) so that its pop never overwrites a pending output.
  assign w_drain_issue = (r_state == S_DRAIN) && (r_gap_cnt == '0) &&
                         (!r_out_valid || out_ready) && (r_drain_cnt != CAP_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_CLEAR;
      r_clr_cnt    <= '0;
      r_load_cnt   <= '0;
      r_drain_cnt  <= '0;
      r_n          <= '0;
      r_gap_cnt    <= '0;
      r_keep       <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_root_data  <= '0;
      r_root_wren  <= 1'b0;
      r_update     <= 1'b0;
      r_initialize <= 1'b0;
      r_sort_done  <= 1'b0;
    end else begin
      r_root_wren <= 1'b0;
      r_update    <= 1'b0;
      r_sort_done <= 1'b0;

      if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end

      if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end

      // Issue cycle of a kept drain op: root_q holds the current minimum.
      if (r_root_wren && r_keep) begin
        r_out_data  <= root_q;
        r_out_valid <= 1'b1;
      end

      case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == CLR_TC) begin
            r_clr_cnt    <= '0;
            r_initialize <= 1'b1;
            r_load_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_state      <= S_LOAD;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_root_data <= in_data;
            r_root_wren <= 1'b1;
            r_update    <= 1'b1;
            r_gap_cnt   <= GAP_RELOAD;
            r_keep      <= 1'b0;
            r_load_cnt  <= r_load_cnt + 1'b1;
            if (in_last || (r_load_cnt == CAP_M1)) begin
              r_n         <= r_load_cnt + 1'b1;
              r_drain_cnt <= '0;
              r_state     <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (w_drain_issue) begin
            r_root_data <= '1;
            r_root_wren <= 1'b1;
            r_update    <= 1'b1;
            r_gap_cnt   <= GAP_RELOAD;
            // The first CAPACITY-N pops are the zero pads from clear.
            r_keep      <= (r_drain_cnt >= (CAP_C - r_n));
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
          // Once all ops are issued, the only word that can be pending is
          // the last one, so its handshake ends the batch.
          if (w_out_hs && (r_drain_cnt == CAP_C)) begin
            r_sort_done  <= 1'b1;
            r_initialize <= 1'b0;
            r_keep       <= 1'b0;
            r_clr_cnt    <= '0;
            r_state      <= S_CLEAR;
          end
        end

        default: begin
          r_state <= S_CLEAR;
        end
      endcase
    end
  end

  assign in_ready            = w_in_ready;
  assign out_data            = r_out_data;
  assign out_valid           = r_out_valid;
  assign root_data           = r_root_data;
  assign root_addr           = 1'b0;
  assign root_wren           = r_root_wren;
  assign initialize          = r_initialize;
  assign update_out          = r_update;
  assign address_updated_out = 1'b0;
  assign sort_done           = r_sort_done;

endmodule

// File: tb/tb_heap_sort_controller.sv
// tb_heap_sort_controller
//   Drives batches into heap_sort_controller with a behavioural heap standing
//   in for the sorting-node array behind the root record. Expected output of
//   each batch is simply the batch sorted ascending.
module tb_heap_sort_controller;

  localparam int WIDTH     = 15;
  localparam int CAP       = 7;
  localparam int ISSUE_GAP = 4;

  typedef logic [WIDTH:0] word_t;
  typedef word_t heap_t [CAP];

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  word_t in_data = '0;
  logic  in_valid = 1'b0;
  logic  in_last = 1'b0;
  logic  out_ready = 1'b1;
  word_t root_q = '0;

  logic  in_ready;
  word_t out_data;
  logic  out_valid;
  word_t root_data;
  logic  root_addr;
  logic  root_wren;
  logic  initialize;
  logic  update_out;
  logic  address_updated_out;
  logic  sort_done;

  heap_t heap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  heap_sort_controller #(
    .WIDTH(WIDTH), .LEVELS(2), .CLEAR_CYCLES(8), .ISSUE_GAP(ISSUE_GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .root_q(root_q), .root_data(root_data), .root_addr(root_addr), .root_wren(root_wren),
    .initialize(initialize), .update_out(update_out),
    .address_updated_out(address_updated_out), .sort_done(sort_done)
  );

  // Environment: min-heap replace-top behind a 1-cycle-latency root read.
  function automatic heap_t replace_top(heap_t h, word_t v);
    int    i;
    int    c;
    word_t t;
    h[0] = v;
    i = 0;
    while (2 * i + 1 < CAP) begin
      c = 2 * i + 1;
      if ((c + 1 < CAP) && (h[c+1] < h[c])) c = c + 1;
      if (h[c] < h[i]) begin
        t = h[i]; h[i] = h[c]; h[c] = t;
        i = c;
      end else begin
        break;
      end
    end
    return h;
  endfunction

  always @(posedge clk) begin
    if (!initialize) heap <= '{default: '0};
    else if (root_wren) heap <= replace_top(heap, root_data);
    root_q <= heap[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_batch(input word_t items[$], input bit use_last, input bit rand_valid,
                           input bit rand_ready, input bit stall, input bit abort);
    word_t exp[$];
    word_t got[$];
    word_t stall_data = '0;
    int    idx = 0;
    int    cyc = 0;
    int    last_acc = 0;
    int    upd = 0;
    int    stall_left = 0;
    bit    stall_pending = stall;
    bit    stall_bad = 1'b0;
    bit    leak = 1'b0;
    bit    done = 1'b0;
    bit    prev_init = 1'b1;
    bit    init_ok = 1'b0;
    exp = items;
    exp.sort();
    while (!done && cyc < 3000) begin
      if (sort_done) begin
        done = 1'b1;
        init_ok = !initialize && prev_init;
      end else begin
        upd += int'(update_out);
        if (idx < items.size()) begin
          in_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
          in_data  = items[idx];
          in_last  = use_last && (idx == items.size() - 1);
          if (in_valid && in_ready) begin
            if (!rand_valid && idx > 0) chk("accept_gap", cyc - last_acc, ISSUE_GAP);
            last_acc = cyc;
            idx++;
          end
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
          if (in_ready) leak = 1'b1;
        end
        if (abort && out_valid) begin
          rst = 1'b1;
          in_valid = 1'b0;
          in_last = 1'b0;
          @(negedge clk);
          chk("abort_out_valid", out_valid, 0);
          chk("abort_initialize", initialize, 0);
          rst = 1'b0;
          return;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          if (out_data !== stall_data || update_out) stall_bad = 1'b1;
          stall_left--;
        end else if (stall_pending && out_valid) begin
          stall_pending = 1'b0;
          stall_data = out_data;
          stall_left = 9;
          out_ready = 1'b0;
        end else begin
          out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (out_valid && out_ready) got.push_back(out_data);
        end
        prev_init = initialize;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    chk("batch_done", done, 1);
    chk("done_with_init_fall", init_ok, 1);
    chk("done_pulse_width", sort_done, 0);
    chk("out_count", got.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      if (k < got.size()) chk("out_word", got[k], exp[k]);
    end
    chk("update_pulses", upd, items.size() + CAP);
    chk("ready_outside_load", leak, 0);
    if (stall) chk("stall_hold", stall_bad, 0);
  endtask

  initial begin
    word_t q[$];
    int    cyc;
    int    lows;
    bit    noisy;
    int    len;
    int    sel;
    bit    ul;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {initialize, in_ready, out_valid, root_wren, update_out, sort_done}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_root_data", root_data, 0);

    rst = 1'b0;
    cyc = 1;
    lows = 0;
    noisy = 1'b0;
    while (!in_ready && cyc < 50) begin
      if (!initialize) lows++;
      if (out_valid || root_wren || update_out || sort_done || out_data != '0 || root_data != '0)
        noisy = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("first_ready_cycle", cyc, 9);
    chk("init_low_cycles", lows, 8);
    chk("init_high_at_ready", initialize, 1);
    chk("quiet_before_ready", noisy, 0);
    chk("const_outputs", {root_addr, address_updated_out}, 0);

    q = '{16'd9, 16'd3, 16'd12, 16'd1, 16'd7, 16'd5, 16'd2};
    run_batch(q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    q = '{16'd40, 16'd10, 16'd25};
    run_batch(q, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    q = '{16'd0, 16'd65535, 16'd0};
    run_batch(q, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    q = '{16'd300, 16'd7, 16'd1000, 16'd7};
    run_batch(q, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int b = 0; b < 6; b++) begin
      q.delete();
      len = $urandom_range(1, CAP);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) q.push_back('0);
        else if (sel == 1) q.push_back('1);
        else q.push_back(word_t'($urandom));
      end
      ul = (len < CAP) ? 1'b1 : 1'($urandom_range(0, 1));
      run_batch(q, ul, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    q = '{16'd50, 16'd20, 16'd30, 16'd10};
    run_batch(q, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    q = '{16'd4, 16'd2};
    run_batch(q, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
